// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for two 4-digit 7-segment groups. One digit
// position is scanned per scan tick. Each position drives one digit of the
// low group (digits 3..0 on seg_30) and one digit of the high group
// (digits 7..4 on seg_74) at the same time.
//
// All display inputs (nibbles, blank/blink/dp masks) are copied into shadow
// registers once per frame, so a digit never shows a mix of old and new
// data within one frame. A frame is four scan ticks.
//
// Parameters
//   CLK_DIV       clk cycles per scan tick (>= 2)
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//
// Ports
//   clk           system clock, all state on rising edge
//   buttom_rst    asynchronous active-low reset
//   sign7..sign0  hex nibble per digit, sign7 leftmost
//   blank         bit i = 1: digit i dark
//   blink         bit i = 1: digit i dark while blink phase is 1
//   dp            bit i = 1: decimal point of digit i lit
//   disp_en       0 forces every digit enable off from the next clk edge
//   tub           digit enables, active-high, bit i = digit i
//   seg_74        segments {a,b,c,d,e,f,g,dp} of the lit digit in tub[7:4]
//   seg_30        segments {a,b,c,d,e,f,g,dp} of the lit digit in tub[3:0]
// ---------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int unsigned CLK_DIV      = 100000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       buttom_rst,
    input  logic [3:0] sign7,
    input  logic [3:0] sign6,
    input  logic [3:0] sign5,
    input  logic [3:0] sign4,
    input  logic [3:0] sign3,
    input  logic [3:0] sign2,
    input  logic [3:0] sign1,
    input  logic [3:0] sign0,
    input  logic [7:0] blank,
    input  logic [7:0] blink,
    input  logic [7:0] dp,
    input  logic       disp_en,
    output logic [7:0] tub,
    output logic [7:0] seg_74,
    output logic [7:0] seg_30
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    // Hex digit to segments {a,b,c,d,e,f,g}; the dp bit is appended separately.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             phase_q, phase_d;
    logic             disp_en_q, disp_en_d;

    logic [7:0][3:0]  sh_sign_q, sh_sign_d;
    logic [7:0]       sh_blank_q, sh_blank_d;
    logic [7:0]       sh_blink_q, sh_blink_d;
    logic [7:0]       sh_dp_q, sh_dp_d;

    logic [7:0]       tub_q, tub_d;
    logic [7:0]       seg_74_q, seg_74_d;
    logic [7:0]       seg_30_q, seg_30_d;

    logic [7:0][3:0]  sign_in;
    logic             tick;
    logic             frame_wrap;

    logic [2:0]       dig_lo;
    logic [2:0]       dig_hi;
    logic             dark_lo;
    logic             dark_hi;
    logic [6:0]       dec_lo;
    logic [6:0]       dec_hi;

    assign sign_in = {sign7, sign6, sign5, sign4, sign3, sign2, sign1, sign0};

    assign tick       = (div_q == DIV_LAST);
    assign frame_wrap = tick && (idx_q == 2'd3);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        div_d       = tick ? '0 : div_q + 1'b1;
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        disp_en_d   = disp_en;

        sh_sign_d   = sh_sign_q;
        sh_blank_d  = sh_blank_q;
        sh_blink_d  = sh_blink_q;
        sh_dp_d     = sh_dp_q;

        // Frame boundary: latch a coherent copy of all display inputs and
        // advance the blink timebase.
        if (frame_wrap) begin
            sh_sign_d  = sign_in;
            sh_blank_d = blank;
            sh_blink_d = blink;
            sh_dp_d    = dp;
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        // Outputs for the tick are built from the post-tick position,
        // shadow and phase so the new frame is visible on its first digit.
        dig_lo  = {1'b0, idx_d};
        dig_hi  = {1'b1, idx_d};
        dark_lo = sh_blank_d[dig_lo] | (sh_blink_d[dig_lo] & phase_d);
        dark_hi = sh_blank_d[dig_hi] | (sh_blink_d[dig_hi] & phase_d);
        dec_lo  = decode_hex(sh_sign_d[dig_lo]);
        dec_hi  = decode_hex(sh_sign_d[dig_hi]);

        tub_d    = tub_q;
        seg_74_d = seg_74_q;
        seg_30_d = seg_30_q;

        if (tick) begin
            tub_d         = '0;
            tub_d[dig_lo] = disp_en_d & ~dark_lo;
            tub_d[dig_hi] = disp_en_d & ~dark_hi;
            seg_30_d      = dark_lo ? 8'h00 : {dec_lo, sh_dp_d[dig_lo]};
            seg_74_d      = dark_hi ? 8'h00 : {dec_hi, sh_dp_d[dig_hi]};
        end

        // Display disable acts on the very next edge, independent of ticks;
        // segments keep their value so re-enable is clean at the next tick.
        if (!disp_en_d) begin
            tub_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge buttom_rst) begin
        if (!buttom_rst) begin
            div_q       <= '0;
            idx_q       <= 2'd3;   // first tick is then a frame wrap
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
            disp_en_q   <= 1'b0;
            sh_sign_q   <= '0;
            sh_blank_q  <= '0;
            sh_blink_q  <= '0;
            sh_dp_q     <= '0;
            tub_q       <= '0;
            seg_74_q    <= '0;
            seg_30_q    <= '0;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            disp_en_q   <= disp_en_d;
            sh_sign_q   <= sh_sign_d;
            sh_blank_q  <= sh_blank_d;
            sh_blink_q  <= sh_blink_d;
            sh_dp_q     <= sh_dp_d;
            tub_q       <= tub_d;
            seg_74_q    <= seg_74_d;
            seg_30_q    <= seg_30_d;
        end
    end

    assign tub    = tub_q;
    assign seg_74 = seg_74_q;
    assign seg_30 = seg_30_q;

    // disp_en_q mirrors the sampled enable; the enable path itself uses the
    // value being sampled so the force-off lands on the next edge.
    logic unused_ok;
    assign unused_ok = disp_en_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Directed bench for seg_scan_driver with CLK_DIV=4, BLINK_FRAMES=2.
// Outputs are sampled 1 time unit after the rising edge.
// After each reset release (done on a falling edge) scan tick j lands on the
// 4*j-th rising edge; tick j shows position (j-1)%4 of frame (j-1)/4+1.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int CLK_DIV      = 4;
    localparam int BLINK_FRAMES = 2;

    logic       clk = 1'b0;
    logic       buttom_rst;
    logic [3:0] sign7, sign6, sign5, sign4, sign3, sign2, sign1, sign0;
    logic [7:0] blank, blink, dp;
    logic       disp_en;
    logic [7:0] tub, seg_74, seg_30;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected patterns for digits 7..0 with nibble value == digit index.
    localparam logic [7:0] TUB_P [4] = '{8'h11, 8'h22, 8'h44, 8'h88};
    localparam logic [7:0] S30_P [4] = '{8'hFC, 8'h60, 8'hDA, 8'hF2};
    localparam logic [7:0] S74_P [4] = '{8'h66, 8'hB6, 8'hBE, 8'hE0};

    seg_scan_driver #(
        .CLK_DIV      (CLK_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .buttom_rst (buttom_rst),
        .sign7      (sign7),
        .sign6      (sign6),
        .sign5      (sign5),
        .sign4      (sign4),
        .sign3      (sign3),
        .sign2      (sign2),
        .sign1      (sign1),
        .sign0      (sign0),
        .blank      (blank),
        .blink      (blink),
        .dp         (dp),
        .disp_en    (disp_en),
        .tub        (tub),
        .seg_74     (seg_74),
        .seg_30     (seg_30)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got t=%0t required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_default_inputs();
        sign7 = 4'd7; sign6 = 4'd6; sign5 = 4'd5; sign4 = 4'd4;
        sign3 = 4'd3; sign2 = 4'd2; sign1 = 4'd1; sign0 = 4'd0;
        blank = 8'h00; blink = 8'h00; dp = 8'h00; disp_en = 1'b1;
    endtask

    // Leaves the bench on a falling edge with reset just released.
    task automatic do_reset();
        buttom_rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        buttom_rst = 1'b1;
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic step_tick();
        repeat (CLK_DIV) step_clk();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        logic [23:0] exp;
        buttom_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sign7 = 4'(i); sign6 = 4'(i+1); sign5 = 4'(i+2); sign4 = 4'(i+3);
            sign3 = 4'(i+4); sign2 = 4'(i+5); sign1 = 4'(i+6); sign0 = 4'(i+7);
            blank = 8'(i * 37); blink = 8'(i * 91); dp = 8'(i * 53);
            disp_en = i[0];
            step_clk();
            exp = 24'h000000;
            n_cmp++;
            if ({tub, seg_74, seg_30} !== exp) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got %h required %h", i, {tub, seg_74, seg_30}, exp);
            end
        end
        set_default_inputs();
        @(negedge clk);
        buttom_rst = 1'b1;
        repeat (3) step_clk();
        n_cmp++;
        if ({tub, seg_74, seg_30} !== 24'h000000) begin
            n_bad++;
            $display("FAIL reset_pre_tick: got %h required 000000", {tub, seg_74, seg_30});
        end
        step_clk();
        exp = {8'h11, 8'h66, 8'hFC};
        n_cmp++;
        if ({tub, seg_74, seg_30} !== exp) begin
            n_bad++;
            $display("FAIL reset_first_tick: got %h required %h", {tub, seg_74, seg_30}, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_scan();
        logic [23:0] exp;
        set_default_inputs();
        do_reset();
        for (int j = 1; j <= 8; j++) begin
            step_tick();
            exp = {TUB_P[(j-1)%4], S74_P[(j-1)%4], S30_P[(j-1)%4]};
            n_cmp++;
            if ({tub, seg_74, seg_30} !== exp) begin
                n_bad++;
                $display("FAIL scan_tick[%0d]: got %h required %h", j, {tub, seg_74, seg_30}, exp);
            end
        end
        // Outputs hold between ticks.
        repeat (CLK_DIV - 1) step_clk();
        exp = {8'h88, 8'hE0, 8'hF2};
        n_cmp++;
        if ({tub, seg_74, seg_30} !== exp) begin
            n_bad++;
            $display("FAIL scan_hold: got %h required %h", {tub, seg_74, seg_30}, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_tearing();
        set_default_inputs();
        do_reset();
        step_tick();          // frame 1 position 0, snapshot taken
        sign1 = 4'hF;
        step_tick();          // frame 1 position 1
        n_cmp++;
        if (seg_30 !== 8'h60) begin
            n_bad++;
            $display("FAIL tear_same_frame: got %h required 60", seg_30);
        end
        repeat (4) step_tick(); // frame 2 position 1
        n_cmp++;
        if (seg_30 !== 8'h8E) begin
            n_bad++;
            $display("FAIL tear_next_frame: got %h required 8E", seg_30);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_blink_blank_dp();
        logic [7:0]  e_tub, e_s30, e_s74;
        logic        ph;
        int          p, n;
        set_default_inputs();
        blink = 8'h01;
        blank = 8'h10;
        dp    = 8'h02;
        do_reset();
        for (int j = 1; j <= 20; j++) begin
            step_tick();
            p  = (j - 1) % 4;
            n  = (j - 1) / 4 + 1;
            // Phase toggles on every second frame wrap: frames 1,2,3,4,5 -> 0,1,1,0,0.
            ph = ((n / 2) % 2) == 1;
            e_tub = TUB_P[p];
            e_s30 = S30_P[p];
            e_s74 = S74_P[p];
            if (p == 0) begin
                e_tub = 8'h00;          // digit4 blanked
                e_s74 = 8'h00;
                if (ph) begin
                    e_s30 = 8'h00;
                end else begin
                    e_tub = 8'h01;
                end
            end
            if (p == 1) begin
                e_s30 = 8'h61;          // dp of digit1
            end
            n_cmp++;
            if ({tub, seg_74, seg_30} !== {e_tub, e_s74, e_s30}) begin
                n_bad++;
                $display("FAIL blink_tick[%0d]: got %h required %h", j,
                         {tub, seg_74, seg_30}, {e_tub, e_s74, e_s30});
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_disp_en();
        set_default_inputs();
        do_reset();
        step_tick();
        @(negedge clk);
        disp_en = 1'b0;
        step_clk();
        n_cmp++;
        if ({tub, seg_30} !== {8'h00, 8'hFC}) begin
            n_bad++;
            $display("FAIL disp_off: got %h required 00FC", {tub, seg_30});
        end
        @(negedge clk);
        disp_en = 1'b1;
        step_clk();
        step_clk();
        n_cmp++;
        if ({tub, seg_30} !== {8'h00, 8'hFC}) begin
            n_bad++;
            $display("FAIL disp_wait_tick: got %h required 00FC", {tub, seg_30});
        end
        step_clk();
        n_cmp++;
        if ({tub, seg_74, seg_30} !== {8'h22, 8'hB6, 8'h60}) begin
            n_bad++;
            $display("FAIL disp_resume: got %h required 22B660", {tub, seg_74, seg_30});
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_async_reset();
        set_default_inputs();
        do_reset();
        repeat (3) step_tick();   // position 2 shown, idx=2
        n_cmp++;
        if ({tub, seg_74, seg_30} !== {8'h44, 8'hBE, 8'hDA}) begin
            n_bad++;
            $display("FAIL areset_pre: got %h required 44BEDA", {tub, seg_74, seg_30});
        end
        @(negedge clk);
        #2;
        buttom_rst = 1'b0;
        #1;
        n_cmp++;
        if ({tub, seg_74, seg_30} !== 24'h000000) begin
            n_bad++;
            $display("FAIL areset_immediate: got %h required 000000", {tub, seg_74, seg_30});
        end
        step_clk();
        step_clk();
        @(negedge clk);
        buttom_rst = 1'b1;
        repeat (3) step_clk();
        n_cmp++;
        if ({tub, seg_74, seg_30} !== 24'h000000) begin
            n_bad++;
            $display("FAIL areset_restart_pre: got %h required 000000", {tub, seg_74, seg_30});
        end
        step_clk();
        n_cmp++;
        if ({tub, seg_74, seg_30} !== {8'h11, 8'h66, 8'hFC}) begin
            n_bad++;
            $display("FAIL areset_restart: got %h required 1166FC", {tub, seg_74, seg_30});
        end
    endtask

    initial begin
        buttom_rst = 1'b0;
        set_default_inputs();
        test_reset();
        test_scan();
        test_tearing();
        test_blink_blank_dp();
        test_disp_en();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
